// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//
// Initiator side of the arithmetic-unit interface. It takes one operation
// request (two operands and a 3-bit op code) over a valid/ready handshake and
// drives the operands and code into a registered arithmetic unit. It then waits
// the unit's fixed latency, captures the result and flags, and returns them
// over a valid/ready response channel. Only one operation is in flight at a
// time. alu_sel is non-zero only while an operation is in flight.
//
// Op codes whose bit is clear in SUPPORTED never reach the unit. They get an
// immediate error response with zero data.
//
// Parameters
//   WIDTH      operand/result width
//   LATENCY    clock edges from the accept edge to the capture edge (1..15)
//   SUPPORTED  bit n set means op code n is issued to the unit
//
// Ports
//   elk                    clock, all logic on the rising edge
//   rst                    synchronous reset, active-high
//   req_valid/req_ready    request handshake
//   req_opA/req_opB        request operands
//   req_sel                request op code
//   alu_opA/alu_opB        registered operands to the unit
//   alu_sel                registered op code to the unit, 3'b000 when idle
//   alu_res, alu_z/c/v     unit result and flags
//   rsp_valid/rsp_ready    response handshake
//   rsp_res, rsp_z/c/v     captured result and flags
//   rsp_err                request was rejected (unsupported op code)
//   op_count               completed responses, wraps 16'hFFFF -> 16'h0000
// -----------------------------------------------------------------------------
module alu_op_issuer #(
  parameter int         WIDTH     = 32,
  parameter int         LATENCY   = 2,
  parameter logic [7:0] SUPPORTED = 8'b0000_0010
) (
  input  logic             elk,
  input  logic             rst,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_opA,
  input  logic [WIDTH-1:0] req_opB,
  input  logic [2:0]       req_sel,

  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_z,
  output logic             rsp_c,
  output logic             rsp_v,
  output logic             rsp_err,

  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The countdown starts at LATENCY-1 on the accept edge. The capture then
  // lands exactly LATENCY edges after the accept edge. Four bits cover the
  // full 1..15 latency range.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] op_count_q;
  logic        sel_supported;

  // Ready is purely a function of state. Reset masks it in the same cycle so
  // that no request can be accepted on a reset edge.
  assign req_ready = (state == S_IDLE) && !rst;

  // A compile-time mask lookup. This bit decides whether the request goes to
  // the unit or gets an error response.
  assign sel_supported = SUPPORTED[req_sel];

  assign op_count = op_count_q;

  // NOTE: every register here is updated with non-blocking assignments. Then
  // all right-hand sides see the values from before the edge, and the order
  // of the statements does not change the hardware.
  always_ff @(posedge elk) begin
    // NOTE: reset clears every register, and there are no memories. The
    // result and flag fields are zeroed too, so a consumer that peeks at the
    // response never sees X after reset.
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_sel    <= 3'b000;
      rsp_valid  <= 1'b0;
      rsp_res    <= '0;
      rsp_z      <= 1'b0;
      rsp_c      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_err    <= 1'b0;
      op_count_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // req_ready is high whenever rst is low in IDLE, so req_valid alone
          // marks the handshake here.
          if (req_valid) begin
            if (sel_supported) begin
              alu_opA <= req_opA;
              alu_opB <= req_opB;
              alu_sel <= req_sel;
              cnt     <= CNT_INIT;
              state   <= S_WAIT;
            end else begin
              // The unit is never disturbed by a rejected code. The operand
              // registers keep whatever the last real operation left there.
              rsp_res   <= '0;
              rsp_z     <= 1'b0;
              rsp_c     <= 1'b0;
              rsp_v     <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Take the flags bit-exact from the unit. Clearing alu_sel on this
            // same edge means the unit sees a non-zero code only while the
            // operation is actually in flight.
            rsp_res   <= alu_res;
            rsp_z     <= alu_z;
            rsp_c     <= alu_c;
            rsp_v     <= alu_v;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            alu_sel   <= 3'b000;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          // rsp_valid is always high in this state. The data fields are left
          // alone after the handshake, so they keep their last values.
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            op_count_q <= op_count_q + 16'd1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state   <= S_IDLE;
          alu_sel <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issuer
//
// Directed bench for alu_op_issuer. The main instance (LATENCY=2) drives a
// single-register subtraction unit. A second instance (LATENCY=4) drives a
// three-register subtraction pipeline. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_op_issuer;

  localparam int W = 32;

  logic          elk = 1'b0;
  logic          rst;
  logic          rsp_ready;
  logic [W-1:0]  req_opA, req_opB;
  logic [2:0]    req_sel;

  // Main instance, LATENCY=2.
  logic          req_valid, req_ready;
  logic [W-1:0]  alu_opA, alu_opB, alu_res;
  logic [2:0]    alu_sel;
  logic          alu_z, alu_c, alu_v;
  logic          rsp_valid, rsp_z, rsp_c, rsp_v, rsp_err;
  logic [W-1:0]  rsp_res;
  logic [15:0]   op_count;

  // Second instance, LATENCY=4.
  logic          req_valid4, req_ready4;
  logic [W-1:0]  alu_opA4, alu_opB4, alu_res4;
  logic [2:0]    alu_sel4;
  logic          alu_z4, alu_c4, alu_v4;
  logic          rsp_valid4, rsp_z4, rsp_c4, rsp_v4, rsp_err4;
  logic [W-1:0]  rsp_res4;
  logic [15:0]   op_count4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 elk = ~elk;

  alu_op_issuer #(.WIDTH(W), .LATENCY(2), .SUPPORTED(8'b0000_0010)) dut (
    .elk(elk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_sel(req_sel),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  alu_op_issuer #(.WIDTH(W), .LATENCY(4), .SUPPORTED(8'b0000_0010)) dut4 (
    .elk(elk), .rst(rst),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_opA(req_opA), .req_opB(req_opB), .req_sel(req_sel),
    .alu_opA(alu_opA4), .alu_opB(alu_opB4), .alu_sel(alu_sel4),
    .alu_res(alu_res4), .alu_z(alu_z4), .alu_c(alu_c4), .alu_v(alu_v4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res4), .rsp_z(rsp_z4), .rsp_c(rsp_c4), .rsp_v(rsp_v4),
    .rsp_err(rsp_err4), .op_count(op_count4)
  );

  // Registered subtraction unit: carry = no borrow, v = signed overflow.
  logic [W-1:0] diff;
  assign diff = alu_opA - alu_opB;
  always_ff @(posedge elk) begin
    alu_res <= diff;
    alu_z   <= (diff == '0);
    alu_c   <= (alu_opA >= alu_opB);
    alu_v   <= (alu_opA[W-1] != alu_opB[W-1]) && (diff[W-1] != alu_opA[W-1]);
  end

  // Three-stage subtraction pipeline, so results land for a 4-edge capture.
  logic [W-1:0] p1, p2;
  always_ff @(posedge elk) begin
    p1       <= alu_opA4 - alu_opB4;
    p2       <= p1;
    alu_res4 <= p2;
    alu_z4   <= (p2 == '0);
    alu_c4   <= 1'b1;
    alu_v4   <= 1'b0;
  end

  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] s);
    req_opA   = a;
    req_opB   = b;
    req_sel   = s;
    req_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_valid4 = 1'b0; rsp_ready = 1'b0;
    req_opA = '0; req_opB = '0; req_sel = 3'b000;
    repeat (2) @(negedge elk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready); end
    n_cmp++; if (alu_sel !== 3'b000) begin n_bad++; $display("FAIL reset_alu_sel: got %b want 000", alu_sel); end
    n_cmp++; if (alu_opA !== '0 || alu_opB !== '0) begin n_bad++; $display("FAIL reset_alu_ops: got %h/%h want 0/0", alu_opA, alu_opB); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if ({rsp_res, rsp_z, rsp_c, rsp_v, rsp_err} !== '0) begin n_bad++; $display("FAIL reset_rsp_fields: got %h %b%b%b%b want all 0", rsp_res, rsp_z, rsp_c, rsp_v, rsp_err); end
    n_cmp++; if (op_count !== 16'h0000) begin n_bad++; $display("FAIL reset_op_count: got %h want 0000", op_count); end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_basic_sub();
    rsp_ready = 1'b1;
    drive_req(32'd5, 32'd3, 3'b001);
    @(negedge elk);                       // accept edge passed
    req_valid = 1'b0;
    n_cmp++; if (alu_sel !== 3'b001 || alu_opA !== 32'd5 || alu_opB !== 32'd3) begin n_bad++; $display("FAIL basic_issue: got sel=%b a=%h b=%h want 001/5/3", alu_sel, alu_opA, alu_opB); end
    n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_wait1: got ready=%b valid=%b want 0/0", req_ready, rsp_valid); end
    @(negedge elk);                       // one edge after accept
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", rsp_valid); end
    @(negedge elk);                       // capture edge
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_res !== 32'd2 || rsp_z !== 1'b0 || rsp_c !== 1'b1 || rsp_v !== 1'b0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL basic_data: got res=%h zcv=%b%b%b err=%b want 2 010 0", rsp_res, rsp_z, rsp_c, rsp_v, rsp_err); end
    n_cmp++; if (alu_sel !== 3'b000) begin n_bad++; $display("FAIL basic_sel_clear: got %b want 000", alu_sel); end
    @(negedge elk);                       // handshake edge
    n_cmp++; if (rsp_valid !== 1'b0 || op_count !== 16'd1 || req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_done: got valid=%b cnt=%h ready=%b want 0/0001/1", rsp_valid, op_count, req_ready); end
    n_cmp++; if (rsp_res !== 32'd2) begin n_bad++; $display("FAIL basic_res_kept: got %h want 2", rsp_res); end
  endtask

  task automatic test_borrow();
    rsp_ready = 1'b1;
    drive_req(32'd3, 32'd5, 3'b001);
    @(negedge elk);
    req_valid = 1'b0;
    repeat (2) @(negedge elk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL borrow_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_res !== 32'hFFFF_FFFE || rsp_c !== 1'b0 || rsp_z !== 1'b0 || rsp_v !== 1'b0) begin n_bad++; $display("FAIL borrow_data: got res=%h zcv=%b%b%b want fffffffe 000", rsp_res, rsp_z, rsp_c, rsp_v); end
    @(negedge elk);
    n_cmp++; if (op_count !== 16'd2) begin n_bad++; $display("FAIL borrow_count: got %h want 0002", op_count); end
  endtask

  task automatic test_unsupported();
    rsp_ready = 1'b0;
    drive_req(32'd9, 32'd1, 3'b010);
    @(negedge elk);
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_bad++; $display("FAIL unsup_valid_err: got valid=%b err=%b want 1/1", rsp_valid, rsp_err); end
    n_cmp++; if (rsp_res !== '0 || {rsp_z, rsp_c, rsp_v} !== 3'b000) begin n_bad++; $display("FAIL unsup_data: got res=%h zcv=%b%b%b want 0 000", rsp_res, rsp_z, rsp_c, rsp_v); end
    n_cmp++; if (alu_sel !== 3'b000 || alu_opA !== 32'd3) begin n_bad++; $display("FAIL unsup_alu_untouched: got sel=%b a=%h want 000/3", alu_sel, alu_opA); end
    rsp_ready = 1'b1;
    @(negedge elk);
    n_cmp++; if (rsp_valid !== 1'b0 || op_count !== 16'd3 || rsp_err !== 1'b1) begin n_bad++; $display("FAIL unsup_done: got valid=%b cnt=%h err=%b want 0/0003/1", rsp_valid, op_count, rsp_err); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    drive_req(32'd5, 32'd3, 3'b001);
    @(negedge elk);
    req_valid = 1'b0;
    repeat (2) @(negedge elk);
    // New request waits while the response is stalled.
    drive_req(32'd100, 32'd1, 3'b001);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_res !== 32'd2 || rsp_c !== 1'b1 || req_ready !== 1'b0 || alu_sel !== 3'b000 || alu_opA !== 32'd5) begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b res=%h c=%b rdy=%b sel=%b a=%h want 1/2/1/0/000/5", i, rsp_valid, rsp_res, rsp_c, req_ready, alu_sel, alu_opA); end
      @(negedge elk);
    end
    rsp_ready = 1'b1;
    @(negedge elk);                       // handshake edge
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_sel !== 3'b000 || op_count !== 16'd4) begin n_bad++; $display("FAIL bp_release: got v=%b rdy=%b sel=%b cnt=%h want 0/1/000/0004", rsp_valid, req_ready, alu_sel, op_count); end
    @(negedge elk);                       // accept edge for the held request
    req_valid = 1'b0;
    n_cmp++; if (alu_sel !== 3'b001 || alu_opA !== 32'd100 || req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got sel=%b a=%h rdy=%b want 001/64/0", alu_sel, alu_opA, req_ready); end
    repeat (2) @(negedge elk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_res !== 32'd99) begin n_bad++; $display("FAIL bp_second_rsp: got v=%b res=%h want 1/63", rsp_valid, rsp_res); end
    @(negedge elk);
    n_cmp++; if (op_count !== 16'd5) begin n_bad++; $display("FAIL bp_count: got %h want 0005", op_count); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    drive_req(32'd7, 32'd2, 3'b001);
    @(negedge elk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge elk);
    n_cmp++; if (alu_sel !== 3'b000 || rsp_valid !== 1'b0 || op_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst: got sel=%b v=%b cnt=%h want 000/0/0000", alu_sel, rsp_valid, op_count); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge elk);
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_quiet[%0d]: got v=%b rdy=%b want 0/1", i, rsp_valid, req_ready); end
    end
  endtask

  task automatic test_count_wrap();
    rsp_ready = 1'b1;
    force dut.op_count_q = 16'hFFFE;
    @(negedge elk);
    release dut.op_count_q;
    for (int k = 0; k < 2; k++) begin
      drive_req(32'd1, 32'd1, 3'b111);
      @(negedge elk);                     // accept
      req_valid = 1'b0;
      @(negedge elk);                     // handshake
    end
    n_cmp++; if (op_count !== 16'h0000) begin n_bad++; $display("FAIL count_wrap: got %h want 0000", op_count); end
  endtask

  task automatic test_latency4();
    rsp_ready   = 1'b1;
    req_opA     = 32'd10;
    req_opB     = 32'd4;
    req_sel     = 3'b001;
    req_valid4  = 1'b1;
    @(negedge elk);                       // accept edge
    req_valid4 = 1'b0;
    n_cmp++; if (alu_sel4 !== 3'b001) begin n_bad++; $display("FAIL lat4_issue: got %b want 001", alu_sel4); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge elk);
      n_cmp++; if (rsp_valid4 !== 1'b0) begin n_bad++; $display("FAIL lat4_early[%0d]: got %b want 0", i, rsp_valid4); end
    end
    @(negedge elk);                       // 4th edge after accept
    n_cmp++; if (rsp_valid4 !== 1'b1 || rsp_res4 !== 32'd6 || alu_sel4 !== 3'b000) begin n_bad++; $display("FAIL lat4_capture: got v=%b res=%h sel=%b want 1/6/000", rsp_valid4, rsp_res4, alu_sel4); end
    @(negedge elk);
    n_cmp++; if (rsp_valid4 !== 1'b0 || op_count4 !== 16'd1) begin n_bad++; $display("FAIL lat4_done: got v=%b cnt=%h want 0/0001", rsp_valid4, op_count4); end
  endtask

  initial begin
    test_reset();
    test_basic_sub();
    test_borrow();
    test_unsupported();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    test_latency4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Initiator side of the arithmetic-unit interface. It accepts an operation request (operands plus sel code) over a valid/ready handshake and drives opA/opB/sel into a registered arithmetic unit such as the subtraction unit. It waits the unit's fixed latency, captures res/z/c/v and returns them over a valid/ready response channel. It sits between the datapath controller and the arithmetic units and ensures sel is only non-zero while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width.
LATENCY, 2, clock edges from the accept edge to the capture edge of alu_res and flags; legal range 1..15; use 2 for the registered subtraction unit.
SUPPORTED, 8'b0000_0010, bit n set means sel code n is issued to the unit; all other codes are rejected.

Ports:
elk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept; equals (state==IDLE) and not rst
req_opA  in  WIDTH  operand A
req_opB  in  WIDTH  operand B
req_sel  in  3  operation code
alu_opA  out  WIDTH  registered operand A to unit
alu_opB  out  WIDTH  registered operand B to unit
alu_sel  out  3  registered op code to unit; 3'b000 when idle
alu_res  in  WIDTH  unit result
alu_z  in  1  unit zero flag
alu_c  in  1  unit carry flag
alu_v  in  1  unit overflow flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_res  out  WIDTH  captured result
rsp_z, rsp_c, rsp_v  out  1 each  captured flags
rsp_err  out  1  request rejected (unsupported sel)
op_count  out  16  completed responses, wraps 0xFFFF->0x0000

Behaviour:
- Reset: state=IDLE, alu_opA/alu_opB/alu_sel=0, rsp_valid=0, rsp_res/z/c/v/err=0, cnt=0, op_count=0. rst overrides everything. A mid-operation reset discards the in-flight result, forces alu_sel=000 at that edge, and produces no response.
- States: IDLE, WAIT, RESP.
- IDLE, accept when req_valid&&req_ready:
  - Supported sel: latch alu_opA<=req_opA, alu_opB<=req_opB, alu_sel<=req_sel, cnt<=LATENCY-1, go to WAIT.
  - Unsupported sel: do not touch the alu_* outputs. Set rsp_res=0, z=c=v=0, rsp_err=1, rsp_valid=1, go to RESP. rsp_valid is visible 1 edge after accept.
- WAIT:
  - alu_opA/opB/sel are held stable.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: capture rsp_res<=alu_res and rsp_z/c/v<=alu_z/c/v bit-exact (no reinterpretation); set rsp_err<=0, rsp_valid<=1, alu_sel<=000; go to RESP.
  - rsp_valid therefore rises exactly LATENCY edges after the accept edge.
- RESP:
  - All rsp_* outputs are held stable while rsp_valid&&!rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, op_count<=op_count+1 (error responses count too), go to IDLE.
  - rsp_* data fields keep their last values after the handshake.
- No overlap: req_ready=0 in WAIT and RESP, including the handshake cycle. A new accept is possible at the earliest on the edge after return to IDLE. Peak throughput is one op per LATENCY+2 cycles.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored when rsp_valid=0.
- alu_opA/alu_opB retain their last values in IDLE; only alu_sel returns to 000.
- LATENCY=1 captures one edge after accept and is valid only for combinational units.

Test Plan:
1. Basic subtraction (subtraction unit attached, LATENCY=2): req opA=5, opB=3, sel=001, rsp_ready=1 -> rsp_valid high 2 edges after accept; rsp_res=2, rsp_z=0, rsp_c=1, rsp_err=0; alu_sel back to 000 at the capture edge; op_count=1.
2. Borrow: opA=3, opB=5, sel=001 -> rsp_res=0xFFFFFFFE, rsp_c=0; rsp_z/v equal the alu_z/v values sampled at the capture edge.
3. Unsupported code: sel=010, opA=9 -> alu_sel stays 000 throughout; rsp_valid 1 edge after accept with rsp_err=1, rsp_res=0, flags 0; op_count increments on handshake.
4. Backpressure: after scenario 1, hold rsp_ready=0 for 5 cycles while req_valid=1 with new operands -> rsp_res=2 and flags stable; req_ready=0; no second issue. Raise rsp_ready -> IDLE, then the new request is accepted on the following edge.
5. Reset mid-operation: assert rst for 1 cycle in WAIT -> next edge: alu_sel=000, state IDLE, rsp_valid=0, op_count=0; no response ever appears for the dropped request.
6. Counter wrap and LATENCY sweep: preload via 65536 ops (or force) -> op_count 0xFFFF->0x0000. With LATENCY=4, rsp_valid rises exactly 4 edges after accept.
